stream_beat_packer: RTL and testbench

- Destination-side consumer of the gray-counter CDC FIFO.
- Takes narrow beats from the FIFO's dst valid/ready/data output and packs RATIO consecutive beats into one wide word for the wide datapath.
- Handles early packet end (last), per-lane strobes and output backpressure.
- Runs entirely in the destination clock domain.

---
 rtl/stream_beat_packer.sv | 118 +++++++++++
 tb/tb_stream_beat_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_beat_packer.sv
// Packs RATIO narrow beats from the CDC FIFO destination port into one wide word, with
// early-end (last) handling, per-lane strobes and output backpressure. Optional macro
// STREAM_BEAT_PACKER_TIMEOUT_EN adds an idle timeout that force-flushes a partial word.
module stream_beat_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_WIDTH-1:0]       in_data_i,
    input  logic                      in_last_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [IN_WIDTH*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]          out_strb_o,
    output logic                      out_last_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [RATIO-1:0][IN_WIDTH-1:0] pack_q;
    logic [RATIO-1:0][IN_WIDTH-1:0] pack_data;
    logic [RATIO-1:0]               strb_q;
    logic [RATIO-1:0]               pack_strb;
    logic [CW-1:0]                  cnt_q;

    logic [RATIO-1:0][IN_WIDTH-1:0] out_data_q;
    logic [RATIO-1:0]               out_strb_q;
    logic                           out_last_q;
    logic                           out_valid_q;

    logic in_hs;
    logic complete;
    logic flush;

    // The output register is the only backpressure point, so ready never looks at the input side.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign in_hs      = in_valid_i && in_ready_o;
    assign complete   = in_hs && ((cnt_q == LAST_LANE) || in_last_i);

    // Buffer contents as they would look with the current beat dropped into lane cnt_q.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
        pack_data            = pack_q;
        pack_strb            = strb_q;
        pack_data[cnt_q]     = in_data_i;
        pack_strb[cnt_q]     = 1'b1;
    end

`ifdef STREAM_BEAT_PACKER_TIMEOUT_EN
    localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_q;

    // Flush on the TIMEOUT-th idle cycle, only when the output register can take the word.
    assign flush = (cnt_q != '0) && !in_hs && in_ready_o && (idle_q == IDLE_LIMIT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idle_q <= '0;
        end else if (in_hs || flush || (cnt_q == '0)) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_LIMIT) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign flush          = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the pack buffer is reset on purpose, because unfilled lanes of an
            // early-ended word must read as zero.
            pack_q      <= '0;
            strb_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read sees the pre-edge state.
            if (complete || flush) begin
                out_data_q  <= flush ? pack_q : pack_data;
                out_strb_q  <= flush ? strb_q : pack_strb;
                out_last_q  <= complete && in_last_i;
                out_valid_q <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            if (complete || flush) begin
                pack_q <= '0;
                strb_q <= '0;
                cnt_q  <= '0;
            end else if (in_hs) begin
                pack_q <= pack_data;
                strb_q <= pack_strb;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_beat_packer.sv
// Scoreboard bench for stream_beat_packer: a lane model queues expected words as beats are
// accepted, and a negedge monitor pops and compares them on each output handshake.
module tb_stream_beat_packer;

    localparam int unsigned IN_WIDTH = 8;
    localparam int unsigned RATIO    = 4;
    localparam int unsigned TIMEOUT  = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_strb_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready;

    int    n_checks = 0;
    int    n_fails  = 0;
    int    n_words  = 0;
    int    n_queued = 0;
    int    cyc      = 0;
    word_t exp_q[$];

    logic [31:0] m_data;
    logic [3:0]  m_strb;
    int          m_cnt;

    stream_beat_packer #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_data = '0;
        m_strb = '0;
        m_cnt  = 0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        exp_q.push_back('{data: d, strb: s, last: l});
        n_queued++;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic l);
        m_data[m_cnt*8 +: 8] = d;
        m_strb[m_cnt]        = 1'b1;
        if (m_cnt == RATIO - 1 || l) begin
            expect_word(m_data, m_strb, l);
            model_clear();
        end else begin
            m_cnt++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat's accepting edge.
    task automatic push(input logic [7:0] d, input logic l);
        int  waited = 0;
        bit  done   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (in_ready_o) begin
                model_accept(d, l);
                done = 1;
            end else if (++waited > 200) begin
                check("push_wait", in_ready_o, 1'b1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        word_t e;
        if (rst_n && out_valid_o && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_valid_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("word_data", out_data_o, e.data);
                check("word_strb", out_strb_o, e.strb);
                check("word_last", out_last_o, e.last);
                n_words++;
            end
        end
    end

    initial begin
        int t0;
        int k;
        rst_n     = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_data", out_data_o, 32'h0);
        check("rst_strb", out_strb_o, 4'h0);
        check("rst_last", out_last_o, 1'b0);
        check("rst_ready", in_ready_o, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word, back-to-back; valid one cycle after the completing beat.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        check("full_latency", out_valid_o, 1'b1);
        check("full_data_now", out_data_o, 32'h4433_2211);
        wait_drain();

        // Early end on the first beat, then next beat lands in lane 0.
        push(8'hAA, 1'b1);
        push(8'hBB, 1'b1);
        wait_drain();

        // Backpressure: word held stable, input blocked, released the same cycle.
        out_ready = 1'b0;
        push(8'hA1, 1'b0);
        push(8'hB2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hD4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid_o, 1'b1);
            check("stall_ready", in_ready_o, 1'b0);
            check("stall_data", out_data_o, 32'hD4C3_B2A1);
            check("stall_strb", out_strb_o, 4'hF);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", in_ready_o, 1'b1);
        @(posedge clk);
        #1;
        wait_drain();

        // Continuous stream: eight beats in eight cycles.
        t0 = cyc;
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
        check("stream_cycles", cyc - t0, 8);
        wait_drain();

        // Reset mid-packet discards partial lanes.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", out_valid_o, 1'b0);
        check("midrst_data", out_data_o, 32'h0);
        check("midrst_strb", out_strb_o, 4'h0);
        check("midrst_last", out_last_o, 1'b0);
        rst_n = 1'b1;
        model_clear();
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        push(8'h77, 1'b0);
        push(8'h88, 1'b0);
        wait_drain();

        // Partial word left idle.
        push(8'h55, 1'b0);
`ifdef STREAM_BEAT_PACKER_TIMEOUT_EN
        expect_word(32'h0000_0055, 4'b0001, 1'b0);
        model_clear();
        k = 0;
        while (!out_valid_o && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout_latency", k, TIMEOUT);
        wait_drain();
        push(8'h66, 1'b1);
`else
        k = 0;
        repeat (100) @(posedge clk);
        #1;
        check("idle_no_output", out_valid_o, 1'b0);
        push(8'h66, 1'b1);
`endif
        wait_drain();

        check("word_count", n_words, n_queued);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
